instr_mem_responder: RTL and testbench

- Responder end of the CPU instruction-fetch bus: samples the `memory_address_bus` driven by the fetch stage and returns the instruction word on `memory_data_bus`.
- Holds a synchronous word-wide RAM.
- Includes a byte-serial program loader (host side) that assembles little-endian bytes into words and writes them at a start address. This fills program memory before the CPU is released from reset.

---
 rtl/instr_mem_responder_pkg.sv | 34 +++
 rtl/instr_mem_responder_sram.sv | 40 ++++
 rtl/instr_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_instr_mem_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// +--------------------------------------------------------------------------+
// | instr_mem_responder_pkg: loader state codes, defaults, address helpers    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package instr_mem_responder_pkg;

  localparam logic [1:0] LD_IDLE  = 2'd0;
  localparam logic [1:0] LD_LOAD  = 2'd1;
  localparam logic [1:0] LD_FLUSH = 2'd2;

  localparam logic [31:0] OOR_DATA_DEFAULT = 32'h0000_0000;

  // Word offset of a byte address relative to the mapped base; the caller
  // keeps only the low index bits it needs.
  function automatic logic [31:0] addr_to_word(input logic [31:0] addr,
                                               input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return {2'b00, offset[31:2]};
  endfunction

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_log2);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> (depth_log2 + 2)) == 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_responder_sram.sv
// +--------------------------------------------------------------------------+
// | mem_sram_1r1w: synchronous word RAM, one read and one write port,        |
// | read-before-write on a same-address collision.  Revision: 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_sram_1r1w #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // The read captures the pre-write contents because both updates are
  // scheduled on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// +--------------------------------------------------------------------------+
// | instr_mem_responder: instruction-fetch responder with byte-serial        |
// | little-endian program loader.  Revision: 1.0                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] OOR_DATA   = OOR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_address_bus,
  output logic [31:0] memory_data_bus,
  output logic        misaligned,
  input  logic        ld_start,
  input  logic [31:0] ld_addr,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic        ld_end,
  output logic        ld_done,
  output logic        ld_overflow,
  output logic        busy
);

  localparam logic [DEPTH_LOG2-1:0] PTR_MAX = {DEPTH_LOG2{1'b1}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [31:0]           word_q, word_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic                  oor_q, oor_d;
  logic                  misaligned_q, misaligned_d;

  logic [31:0]           fetch_word;
  logic [31:0]           load_word;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic                  ld_in_range;
  logic [31:0]           rd_data;
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic [31:0]           asm_word;
  logic                  unused_idx_hi;

  assign fetch_word    = addr_to_word(memory_address_bus, BASE_ADDR);
  assign load_word     = addr_to_word(ld_addr, BASE_ADDR);
  assign rd_idx        = fetch_word[DEPTH_LOG2-1:0];
  assign ld_idx        = load_word[DEPTH_LOG2-1:0];
  assign ld_in_range   = addr_in_range(ld_addr, BASE_ADDR, DEPTH_LOG2);
  assign unused_idx_hi = ^{fetch_word[31:DEPTH_LOG2], load_word[31:DEPTH_LOG2]};

  mem_sram_1r1w #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (32)
  ) u_sram (
    .clk     (clk),
    .rd_addr (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (ptr_q),
    .wr_data (wr_data)
  );

  always_comb begin
    oor_d        = ~addr_in_range(memory_address_bus, BASE_ADDR, DEPTH_LOG2);
    misaligned_d = |memory_address_bus[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LD_IDLE;
      count_q      <= 2'd0;
      ptr_q        <= '0;
      word_q       <= 32'd0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      oor_q        <= 1'b1;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      word_q       <= word_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      oor_q        <= oor_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = word_q;
    asm_word   = word_q;

    case (state_q)
      LD_IDLE: begin
        if (ld_start) begin
          state_d    = LD_LOAD;
          ptr_d      = ld_idx;
          count_d    = 2'd0;
          word_d     = 32'd0;
          overflow_d = ~ld_in_range;
        end
      end

      LD_LOAD: begin
        if (ld_start) begin
          ptr_d      = ld_idx;
          count_d    = 2'd0;
          word_d     = 32'd0;
          overflow_d = ~ld_in_range;
        end else begin
          case (count_q)
            2'd0:    asm_word[7:0]   = ld_byte;
            2'd1:    asm_word[15:8]  = ld_byte;
            2'd2:    asm_word[23:16] = ld_byte;
            default: asm_word[31:24] = ld_byte;
          endcase
          if (ld_valid) begin
            if (count_q == 2'd3) begin
              wr_en   = 1'b1;
              wr_data = asm_word;
              ptr_d   = ptr_q + PTR_ONE;
              count_d = 2'd0;
              word_d  = 32'd0;
              if (ptr_q == PTR_MAX) begin
                overflow_d = 1'b1;
              end
            end else begin
              count_d = count_q + 2'd1;
              word_d  = asm_word;
            end
          end
          if (ld_end) begin
            if (count_d == 2'd0) begin
              state_d = LD_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = LD_FLUSH;
            end
          end
        end
      end

      LD_FLUSH: begin
        // Unfilled upper lanes are already zero: word_q is cleared on every
        // start and after every completed word.
        wr_en   = 1'b1;
        wr_data = word_q;
        ptr_d   = ptr_q + PTR_ONE;
        count_d = 2'd0;
        word_d  = 32'd0;
        state_d = LD_IDLE;
        done_d  = 1'b1;
        if (ptr_q == PTR_MAX) begin
          overflow_d = 1'b1;
        end
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  always_comb begin
    ld_ready        = (state_q == LD_LOAD);
    busy            = (state_q != LD_IDLE);
    ld_done         = done_q;
    ld_overflow     = overflow_q;
    misaligned      = misaligned_q;
    memory_data_bus = oor_q ? OOR_DATA : rd_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
// +--------------------------------------------------------------------------+
// | tb_instr_mem_responder: scoreboard bench for fetch path and loader.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_mem_responder;

  localparam logic [31:0] OOR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memory_address_bus;
  logic [31:0] memory_data_bus;
  logic        misaligned;
  logic        ld_start;
  logic [31:0] ld_addr;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        ld_end;
  logic        ld_done;
  logic        ld_overflow;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
  } fetch_exp_t;

  fetch_exp_t sb_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(
    .DEPTH_LOG2 (10),
    .BASE_ADDR  (32'h0000_0000),
    .OOR_DATA   (OOR)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .memory_address_bus (memory_address_bus),
    .memory_data_bus    (memory_data_bus),
    .misaligned         (misaligned),
    .ld_start           (ld_start),
    .ld_addr            (ld_addr),
    .ld_valid           (ld_valid),
    .ld_byte            (ld_byte),
    .ld_ready           (ld_ready),
    .ld_end             (ld_end),
    .ld_done            (ld_done),
    .ld_overflow        (ld_overflow),
    .busy               (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] d, input logic m);
    memory_address_bus = a;
    sb_q.push_back(fetch_exp_t'{data: d, mis: m});
  endtask

  task automatic start_load(input logic [31:0] a);
    ld_start = 1'b1;
    ld_addr  = a;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic end_load();
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    memory_address_bus = 32'h12;
    ld_start = 1'b0; ld_addr = 32'd0; ld_valid = 1'b0; ld_byte = 8'd0; ld_end = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({memory_data_bus, misaligned, ld_ready, ld_done, ld_overflow, busy} !== {OOR, 5'b0}) begin
      n_miss++;
      $display("FAIL reset_state: got data=%h mis=%b rdy=%b done=%b ovf=%b busy=%b, expected data=%h others 0",
               memory_data_bus, misaligned, ld_ready, ld_done, ld_overflow, busy, OOR);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    logic [7:0]  bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [31:0] addrs [2] = '{32'h10, 32'h14};
    logic [31:0] datas [2] = '{32'h0000_0013, 32'h0010_0093};
    fetch_exp_t  exp;
    start_load(32'h10);
    n_vec++;
    if ({ld_ready, busy, ld_done} !== 3'b110) begin
      n_miss++;
      $display("FAIL basic_start: got rdy/busy/done=%b%b%b, expected 110", ld_ready, busy, ld_done);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    end_load();
    n_vec++;
    if ({ld_done, busy} !== 2'b10) begin
      n_miss++;
      $display("FAIL basic_done_pulse: got done/busy=%b%b, expected 10", ld_done, busy);
    end
    tick();
    n_vec++;
    if (ld_done !== 1'b0) begin
      n_miss++;
      $display("FAIL basic_done_single: got done=%b, expected 0", ld_done);
    end
    for (int i = 0; i < 2; i++) begin
      push_fetch(addrs[i], datas[i], 1'b0);
      tick();
      exp = sb_q.pop_front();
      n_vec++;
      if (memory_data_bus !== exp.data || misaligned !== exp.mis) begin
        n_miss++;
        $display("FAIL basic_fetch[%0d]: got data=%h mis=%b, expected data=%h mis=%b",
                 i, memory_data_bus, misaligned, exp.data, exp.mis);
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0]  bytes [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    logic [31:0] addrs [2] = '{32'h0, 32'h4};
    logic [31:0] datas [2] = '{32'hDDCC_BBAA, 32'h0000_2211};
    fetch_exp_t  exp;
    start_load(32'h0);
    foreach (bytes[i]) send_byte(bytes[i]);
    end_load();
    n_vec++;
    if ({busy, ld_ready, ld_done} !== 3'b100) begin
      n_miss++;
      $display("FAIL flush_state: got busy/rdy/done=%b%b%b, expected 100", busy, ld_ready, ld_done);
    end
    tick();
    n_vec++;
    if ({busy, ld_done} !== 2'b01) begin
      n_miss++;
      $display("FAIL flush_done: got busy/done=%b%b, expected 01", busy, ld_done);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      push_fetch(addrs[i], datas[i], 1'b0);
      tick();
      exp = sb_q.pop_front();
      n_vec++;
      if (memory_data_bus !== exp.data || misaligned !== exp.mis) begin
        n_miss++;
        $display("FAIL flush_fetch[%0d]: got data=%h mis=%b, expected data=%h mis=%b",
                 i, memory_data_bus, misaligned, exp.data, exp.mis);
      end
    end
  endtask

  task automatic test_back_to_back_misaligned_oor();
    logic [31:0] addrs [5] = '{32'h12, 32'h1000, 32'h17, 32'hFFFF_FFFC, 32'h4};
    logic [31:0] datas [5] = '{32'h0000_0013, OOR, 32'h0010_0093, OOR, 32'h0000_2211};
    logic        miss  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fetch_exp_t  exp;
    for (int i = 0; i < 5; i++) begin
      push_fetch(addrs[i], datas[i], miss[i]);
      tick();
      exp = sb_q.pop_front();
      n_vec++;
      if (memory_data_bus !== exp.data || misaligned !== exp.mis) begin
        n_miss++;
        $display("FAIL b2b_fetch[%0d] addr=%h: got data=%h mis=%b, expected data=%h mis=%b",
                 i, addrs[i], memory_data_bus, misaligned, exp.data, exp.mis);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] addrs [2] = '{32'hFFC, 32'h0};
    logic [31:0] datas [2] = '{32'h0403_0201, 32'h0807_0605};
    fetch_exp_t  exp;
    start_load(32'hFFC);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    n_vec++;
    if (ld_overflow !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_wrap: got ovf=%b, expected 1", ld_overflow);
    end
    for (int i = 5; i <= 8; i++) send_byte(8'(i));
    end_load();
    tick();
    for (int i = 0; i < 2; i++) begin
      push_fetch(addrs[i], datas[i], 1'b0);
      tick();
      exp = sb_q.pop_front();
      n_vec++;
      if (memory_data_bus !== exp.data || misaligned !== exp.mis) begin
        n_miss++;
        $display("FAIL ovf_fetch[%0d]: got data=%h mis=%b, expected data=%h mis=%b",
                 i, memory_data_bus, misaligned, exp.data, exp.mis);
      end
    end
    start_load(32'h100);
    n_vec++;
    if ({ld_overflow, ld_done} !== 2'b00) begin
      n_miss++;
      $display("FAIL ovf_clear: got ovf/done=%b%b, expected 00", ld_overflow, ld_done);
    end
    end_load();
    tick();
    start_load(32'h2004);
    n_vec++;
    if (ld_overflow !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_oor_start: got ovf=%b, expected 1", ld_overflow);
    end
    end_load();
    tick();
  endtask

  task automatic test_restart_and_reset();
    logic [7:0]  first [6] = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h01, 8'h02};
    logic [31:0] addrs [3] = '{32'h30, 32'h40, 32'h50};
    logic [31:0] datas [3] = '{32'h5566_7788, 32'h4443_4241, 32'h0403_0201};
    fetch_exp_t  exp;
    start_load(32'h30);
    foreach (first[i]) send_byte(first[i]);
    ld_start = 1'b1; ld_addr = 32'h40; ld_valid = 1'b1; ld_byte = 8'h99;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i));
    end_load();
    tick();
    start_load(32'h50);
    for (int i = 1; i <= 7; i++) send_byte(8'(i));
    reset = 1'b1;
    tick();
    n_vec++;
    if ({busy, ld_ready, ld_done} !== 3'b000) begin
      n_miss++;
      $display("FAIL reset_midload: got busy/rdy/done=%b%b%b, expected 000", busy, ld_ready, ld_done);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_fetch(addrs[i], datas[i], 1'b0);
      tick();
      exp = sb_q.pop_front();
      n_vec++;
      if (memory_data_bus !== exp.data || misaligned !== exp.mis) begin
        n_miss++;
        $display("FAIL restart_fetch[%0d]: got data=%h mis=%b, expected data=%h mis=%b",
                 i, memory_data_bus, misaligned, exp.data, exp.mis);
      end
    end
  endtask

  task automatic test_read_before_write();
    fetch_exp_t exp;
    start_load(32'h20);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    end_load();
    tick();
    start_load(32'h20);
    for (int i = 0; i < 3; i++) send_byte(8'h22);
    push_fetch(32'h20, 32'h1111_1111, 1'b0);
    send_byte(8'h22);
    exp = sb_q.pop_front();
    n_vec++;
    if (memory_data_bus !== exp.data) begin
      n_miss++;
      $display("FAIL rbw_old: got data=%h, expected data=%h", memory_data_bus, exp.data);
    end
    push_fetch(32'h20, 32'h2222_2222, 1'b0);
    tick();
    exp = sb_q.pop_front();
    n_vec++;
    if (memory_data_bus !== exp.data) begin
      n_miss++;
      $display("FAIL rbw_new: got data=%h, expected data=%h", memory_data_bus, exp.data);
    end
    end_load();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_flush();
    test_back_to_back_misaligned_oor();
    test_overflow();
    test_restart_and_reset();
    test_read_before_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
